// File: rtl/matrix_mult_seq.sv
// Sequential NxN unsigned matrix multiplier.
// One output element per cycle, wrap or saturate on overflow.
module matrix_mult_seq #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sat,
  input  logic [N*N*DW-1:0] a,
  input  logic [N*N*DW-1:0] b,
  output logic [N*N*DW-1:0] res,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int NE = N * N;
  localparam int MW = NE * DW;
  localparam int CW = $clog2(N);
  localparam int SW = 2 * DW + CW;

  typedef enum logic {
    IDLE,
    CALC
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic [MW-1:0] res_q, res_d;
  logic          sat_q, sat_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic [SW-1:0]   sum;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   elem;
  logic            big;
  logic            last;
  int              pa;
  int              pb;
  int              pr;

  // Dot product of row i of A with column j of B, then wrap/saturate.
  always_comb begin
    sum  = '0;
    prod = '0;
    pa   = 0;
    pb   = 0;
    for (int k = 0; k < N; k++) begin
      pa   = (NE - 1 - (int'(row_q) * N + k)) * DW;
      pb   = (NE - 1 - (k * N + int'(col_q))) * DW;
      prod = {{DW{1'b0}}, a_q[pa +: DW]}
           * {{DW{1'b0}}, b_q[pb +: DW]};
      sum  = sum + {{CW{1'b0}}, prod};
    end
    big  = |sum[SW-1:DW];
    elem = (big && sat_q) ? '1 : sum[DW-1:0];
  end

  assign last = (row_q == CW'(N - 1))
             && (col_q == CW'(N - 1));

  // Next-state and register updates for IDLE/CALC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    row_d   = row_q;
    col_d   = col_q;
    pr      = 0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sat_d   = sat;
          ovf_d   = 1'b0;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        pr = NE - 1 - (int'(row_q) * N + int'(col_q));
        res_d[pr*DW +: DW] = elem;
        ovf_d = ovf_q | big;
        if (last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = IDLE;
        end else if (col_q == CW'(N - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: N=2 and N=3 instances,
// directed cases plus random operations against a model.
module tb_matrix_mult_seq;

  logic        clk;
  logic        rst;
  logic        start2, sat2, busy2, done2, ovf2;
  logic [31:0] a2, b2, res2;
  logic        start3, sat3, busy3, done3, ovf3;
  logic [71:0] a3, b3, res3;

  int checks;
  int failures;
  int am[64];
  int bm[64];

  matrix_mult_seq #(.N(2), .DW(8)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .start(start2),
    .sat  (sat2),
    .a    (a2),
    .b    (b2),
    .res  (res2),
    .busy (busy2),
    .done (done2),
    .ovf  (ovf2)
  );

  matrix_mult_seq #(.N(3), .DW(8)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .start(start3),
    .sat  (sat3),
    .a    (a3),
    .b    (b3),
    .res  (res3),
    .busy (busy3),
    .done (done3),
    .ovf  (ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack(input int n,
                                        input int m[64]);
    logic [511:0] v;
    v = '0;
    for (int e = 0; e < n * n; e++)
      v[(n*n-1-e)*8 +: 8] = 8'(m[e]);
    return v;
  endfunction

  // C = A x B with plain integers, then the overflow rule.
  task automatic model(input int n, input int ma[64],
                       input int mb[64], input bit s,
                       output logic [511:0] r,
                       output bit o);
    int c[64];
    o = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += ma[i*n+k] * mb[k*n+j];
        if (acc > 255) begin
          o = 1'b1;
          c[i*n+j] = s ? 255 : acc % 256;
        end else begin
          c[i*n+j] = acc;
        end
      end
    r = pack(n, c);
  endtask

  function automatic logic [127:0] get_res(input int n);
    return (n == 2) ? {96'd0, res2} : {56'd0, res3};
  endfunction

  function automatic logic get_done(input int n);
    return (n == 2) ? done2 : done3;
  endfunction

  function automatic logic get_busy(input int n);
    return (n == 2) ? busy2 : busy3;
  endfunction

  function automatic logic get_ovf(input int n);
    return (n == 2) ? ovf2 : ovf3;
  endfunction

  task automatic run_op(input int n, input int ma[64],
                        input int mb[64], input bit s);
    logic [511:0] pa, pb, er;
    bit           eo;
    int           cyc;
    logic         d;
    model(n, ma, mb, s, er, eo);
    pa = pack(n, ma);
    pb = pack(n, mb);
    @(negedge clk);
    if (n == 2) begin
      a2 = pa[31:0]; b2 = pb[31:0];
      sat2 = s; start2 = 1'b1;
    end else begin
      a3 = pa[71:0]; b3 = pb[71:0];
      sat3 = s; start3 = 1'b1;
    end
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start3 = 1'b0;
    a2 = $urandom; b2 = $urandom; sat2 = ~sat2;
    a3 = {$urandom, $urandom, $urandom};
    b3 = {$urandom, $urandom, $urandom};
    sat3 = ~sat3;
    cyc = 0;
    d = 1'b0;
    while (!d && cyc < 100) begin
      chk("busy_run", get_busy(n), 1'b1);
      @(posedge clk);
      #1;
      cyc++;
      d = get_done(n);
    end
    chk("latency", cyc, n * n);
    chk("res", get_res(n), er[127:0]);
    chk("ovf", get_ovf(n), eo);
    chk("busy_end", get_busy(n), 1'b0);
    @(posedge clk);
    #1;
    chk("done_pulse", get_done(n), 1'b0);
  endtask

  task automatic set_basic();
    for (int e = 0; e < 4; e++) begin
      am[e] = e + 1;
      bm[e] = e + 5;
    end
  endtask

  initial begin
    logic [511:0] pk;
    logic         dn[10];
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start2 = 1'b1; sat2 = 1'b1;
    a2 = 32'hFFFF_FFFF; b2 = 32'hFFFF_FFFF;
    start3 = 1'b1; sat3 = 1'b1;
    a3 = '1; b3 = '1;

    // reset held with start high
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_busy", busy2, 1'b0);
      chk("rst_done", done2, 1'b0);
      chk("rst_res", res2, 32'd0);
      chk("rst_ovf", ovf2, 1'b0);
      chk("rst_busy3", busy3, 1'b0);
    end
    @(negedge clk);
    start2 = 1'b0; start3 = 1'b0; sat2 = 1'b0; sat3 = 1'b0;
    rst = 1'b1;

    // basic
    set_basic();
    run_op(2, am, bm, 1'b0);
    chk("basic_const", res2, 32'h1316_2B32);

    // overflow wrap / saturate
    for (int e = 0; e < 4; e++) begin
      am[e] = 200;
      bm[e] = 200;
    end
    run_op(2, am, bm, 1'b0);
    chk("wrap_const", res2, 32'h8080_8080);
    run_op(2, am, bm, 1'b1);
    chk("sat_const", res2, 32'hFFFF_FFFF);

    // N=3 identity
    for (int e = 0; e < 9; e++) begin
      am[e] = e + 1;
      bm[e] = (e % 4 == 0) ? 1 : 0;
    end
    run_op(3, am, bm, 1'b0);
    chk("n3_const", res3, 72'h01_0203_0405_0607_0809);

    // start during busy, inputs changed mid-operation
    set_basic();
    @(negedge clk);
    pk = pack(2, am); a2 = pk[31:0];
    pk = pack(2, bm); b2 = pk[31:0];
    sat2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b1;
    a2 = 32'hFFFF_FFFF;
    b2 = 32'hFFFF_FFFF;
    for (int e = 2; e < 10; e++) begin
      @(posedge clk);
      #1;
      dn[e] = done2;
      if (e == 4) chk("hs_res1", res2, 32'h1316_2B32);
      if (e == 5) begin
        chk("hs_busy5", busy2, 1'b1);
        start2 = 1'b0;
      end
    end
    for (int e = 2; e < 10; e++)
      chk($sformatf("hs_done_e%0d", e), dn[e],
          (e == 4 || e == 9));
    chk("hs_res2", res2, 32'h0202_0202);
    chk("hs_ovf2", ovf2, 1'b1);

    // reset in the middle of an operation
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_res", res2, 32'd0);
    chk("mid_busy", busy2, 1'b0);
    chk("mid_done", done2, 1'b0);
    chk("mid_ovf", ovf2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("mid_nodone", done2, 1'b0);
      chk("mid_nobusy", busy2, 1'b0);
    end
    set_basic();
    run_op(2, am, bm, 1'b0);

    // random operations
    for (int t = 0; t < 30; t++) begin
      int n;
      int lim;
      n = (t % 4 == 3) ? 3 : 2;
      lim = ($urandom_range(0, 1) == 1) ? 255 : 15;
      for (int e = 0; e < n * n; e++) begin
        am[e] = $urandom_range(0, lim);
        bm[e] = $urandom_range(0, lim);
      end
      run_op(n, am, bm, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
